seg_scan_decoder: RTL



---
 rtl/seg_scan_pkg.sv | 23 ++
 rtl/seg_scan_decoder_seg7_to_bcd.sv | 29 ++
 rtl/seg_scan_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment readback decoder.
// Segment patterns are active-low {a,b,c,d,e,f,g}; anode values are one-hot-low.
package seg_scan_pkg;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;

   localparam logic [3:0] AN_ONES  = 4'b1110;
   localparam logic [3:0] AN_TENS  = 4'b1101;
   localparam logic [3:0] AN_HUND  = 4'b1011;
   localparam logic [3:0] AN_THOUS = 4'b0111;

   localparam logic [3:0] BLANK_PATTERN = 4'hF;

endpackage

// File: rtl/seg_scan_decoder_seg7_to_bcd.sv
// Combinational active-low 7-segment pattern to BCD decoder.
// o_legal is low for any pattern that is not one of the ten digit shapes.
module seg7_to_bcd
   import seg_scan_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_digit,
   output logic       o_legal
);

   always_comb begin
      o_digit = 4'd0;
      o_legal = 1'b1;
      case (i_seg)
         SEG_0:   o_digit = 4'd0;
         SEG_1:   o_digit = 4'd1;
         SEG_2:   o_digit = 4'd2;
         SEG_3:   o_digit = 4'd3;
         SEG_4:   o_digit = 4'd4;
         SEG_5:   o_digit = 4'd5;
         SEG_6:   o_digit = 4'd6;
         SEG_7:   o_digit = 4'd7;
         SEG_8:   o_digit = 4'd8;
         SEG_9:   o_digit = 4'd9;
         default: o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed active-low 4-digit display and republishes complete frames.
// Define SEG_SCAN_BIN_EN to compute the binary value of each frame on val_bin.
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int BLANK_TIMEOUT = 8,
   parameter int BLINK_CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [3:0]             an,
   input  logic [6:0]             seg,
   output logic [3:0]             val1,
   output logic [3:0]             val2,
   output logic [3:0]             val3,
   output logic [3:0]             val4,
   output logic [13:0]            val_bin,
   output logic                   frame_valid,
   output logic                   display_blank,
   output logic [BLINK_CNT_W-1:0] blink_cnt,
   output logic                   seg_err,
   output logic                   an_err
);

   localparam int              BC_W   = $clog2(BLANK_TIMEOUT + 1);
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLANK_TIMEOUT);
   localparam logic [BC_W-1:0] BC_ARM = BC_W'(BLANK_TIMEOUT - 1);

   logic [3:0]             r_sh [4];
   logic [3:0]             r_val [4];
   logic [3:0]             r_mask;
   logic [BC_W-1:0]        r_blank_cnt;
   logic                   r_frame_valid;
   logic                   r_display_blank;
   logic [BLINK_CNT_W-1:0] r_blink_cnt;
   logic                   r_seg_err;
   logic                   r_an_err;

   logic [3:0] w_sel;
   logic       w_blank;
   logic       w_lit;
   logic       w_pub;
   logic [3:0] w_mask_base;
   logic [3:0] w_digit;
   logic       w_legal;

   seg7_to_bcd u_dec (
      .i_seg   (seg),
      .o_digit (w_digit),
      .o_legal (w_legal)
   );

   assign w_sel   = ~an;
   assign w_blank = (an == BLANK_PATTERN);
   assign w_lit   = (w_sel != 4'h0) && ((w_sel & (w_sel - 4'd1)) == 4'h0);
   // A full mask publishes on the following edge; that edge's capture starts the next frame.
   assign w_pub       = (r_mask == 4'hF);
   assign w_mask_base = w_pub ? 4'h0 : r_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh            <= '{default: 4'd0};
         r_val           <= '{default: 4'd0};
         r_mask          <= 4'h0;
         r_blank_cnt     <= '0;
         r_frame_valid   <= 1'b0;
         r_display_blank <= 1'b1;
         r_blink_cnt     <= '0;
         r_seg_err       <= 1'b0;
         r_an_err        <= 1'b0;
      end else begin
         r_frame_valid <= w_pub;
         r_seg_err     <= 1'b0;
         r_an_err      <= 1'b0;
         if (w_pub) begin
            r_val <= r_sh;
         end
         if (w_blank) begin
            r_mask <= 4'h0;
            if (r_blank_cnt != BC_MAX) begin
               r_blank_cnt <= r_blank_cnt + 1'b1;
            end
            if (r_blank_cnt >= BC_ARM) begin
               r_display_blank <= 1'b1;
            end
         end else if (w_lit) begin
            r_blank_cnt <= '0;
            if (r_display_blank) begin
               r_display_blank <= 1'b0;
               if (r_blink_cnt != '1) begin
                  r_blink_cnt <= r_blink_cnt + 1'b1;
               end
            end
            if (w_legal) begin
               for (int i = 0; i < 4; i++) begin
                  if (w_sel[i]) begin
                     r_sh[i] <= w_digit;
                  end
               end
               r_mask <= w_mask_base | w_sel;
            end else begin
               r_seg_err <= 1'b1;
               r_mask    <= 4'h0;
            end
         end else begin
            r_an_err <= 1'b1;
            r_mask   <= w_mask_base;
         end
      end
   end

`ifdef SEG_SCAN_BIN_EN
   logic [13:0] w_bin;
   logic [13:0] r_val_bin;

   assign w_bin = 14'(r_sh[3]) * 14'd1000 + 14'(r_sh[2]) * 14'd100
                + 14'(r_sh[1]) * 14'd10 + 14'(r_sh[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_val_bin <= 14'd0;
      end else if (w_pub) begin
         r_val_bin <= w_bin;
      end
   end

   assign val_bin = r_val_bin;
`else
   assign val_bin = 14'd0;
`endif

   assign val1          = r_val[0];
   assign val2          = r_val[1];
   assign val3          = r_val[2];
   assign val4          = r_val[3];
   assign frame_valid   = r_frame_valid;
   assign display_blank = r_display_blank;
   assign blink_cnt     = r_blink_cnt;
   assign seg_err       = r_seg_err;
   assign an_err        = r_an_err;

endmodule
